// File: rtl/i2c_arbiter_pkg.sv
// rtl/i2c_arbiter_pkg.sv - shared types and widths for the I2C master arbiter
package i2c_arb_pkg;

  localparam int ADDR_W               = 7;
  localparam int DATA_W               = 32;
  localparam int TIMEOUT_CYCLES_DEF   = 4096;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_BUSY   = 2'd2,
    ST_DONE   = 2'd3
  } arb_state_t;

endpackage

// File: rtl/i2c_arbiter_if.sv
// rtl/i2c_arbiter_if.sv - requester-side and master-side signals of the arbiter
interface i2c_arbiter_if #(
  parameter int NUM_REQ = 4
);
  import i2c_arb_pkg::*;

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]        req_rw;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_rdata;
  logic                      rsp_err;
  logic [ADDR_W-1:0]         m_addr;
  logic                      m_rw;
  logic [DATA_W-1:0]         m_wdata;
  logic                      m_enable;
  logic                      m_ready;
  logic [DATA_W-1:0]         m_rdata;
  logic                      busy;

  // slave: the arbiter itself; master: the surrounding requesters and I2C master
  modport slave (
    input  req_valid, req_addr, req_rw, req_wdata, m_ready, m_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           m_addr, m_rw, m_wdata, m_enable, busy
  );

  modport master (
    output req_valid, req_addr, req_rw, req_wdata, m_ready, m_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           m_addr, m_rw, m_wdata, m_enable, busy
  );

endinterface

// File: rtl/i2c_arbiter_rr_pick.sv
// rtl/i2c_arbiter_rr_pick.sv - combinational round-robin picker: first request at or after the pointer
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  int              w_c;
  logic [IW-1:0]   w_ci;

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_c   = 0;
    w_ci  = '0;
    for (int i = 0; i < N; i++) begin
      w_c = int'(i_ptr) + i;
      if (w_c >= N) w_c = w_c - N;
      w_ci = IW'(w_c);
      if (!o_any && i_req[w_ci]) begin
        o_any       = 1'b1;
        o_gnt[w_ci] = 1'b1;
        o_idx       = w_ci;
      end
    end
  end

endmodule

// File: rtl/i2c_arbiter.sv
// rtl/i2c_arbiter.sv - round-robin arbiter sharing one I2C master among NUM_REQ requesters
// Optional per-phase watchdog enabled by defining I2C_ARB_TIMEOUT_EN.
module i2c_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
`ifdef I2C_ARB_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
`endif
) (
  input logic           clk,
  input logic           rst,
  i2c_arbiter_if.slave  bus
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_t          r_state;
  arb_state_t          w_next;
  logic [IW-1:0]       r_ptr;
  logic [IW-1:0]       r_win;
  logic [NUM_REQ-1:0]  w_gnt;
  logic [IW-1:0]       w_idx;
  logic                w_any;
  logic                w_grant;
  logic                w_tmo;

  logic [ADDR_W-1:0]   r_m_addr;
  logic                r_m_rw;
  logic [DATA_W-1:0]   r_m_wdata;
  logic                r_m_enable;
  logic [DATA_W-1:0]   r_rsp_rdata;

  rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .i_req (bus.req_valid),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  assign w_grant = (r_state == ST_IDLE) && bus.m_ready && w_any;

`ifdef I2C_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] r_cnt;
  logic             r_err;

  assign w_tmo = ((r_state == ST_LAUNCH) || (r_state == ST_BUSY)) &&
                 (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Counter restarts on every state change, which covers LAUNCH and BUSY entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if (r_state != w_next)
        r_cnt <= '0;
      else if ((r_state == ST_LAUNCH) || (r_state == ST_BUSY))
        r_cnt <= r_cnt + 1'b1;

      if (w_tmo)
        r_err <= 1'b1;
      else if (r_state == ST_DONE)
        r_err <= 1'b0;
    end
  end

  assign bus.rsp_err = r_err;
`else
  assign w_tmo       = 1'b0;
  assign bus.rsp_err = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_grant) w_next = ST_LAUNCH;
      ST_LAUNCH: if (w_tmo || !bus.m_ready) w_next = (w_tmo ? ST_DONE : ST_BUSY);
      ST_BUSY:   if (w_tmo || bus.m_ready) w_next = ST_DONE;
      ST_DONE:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Command registers hold from LAUNCH entry through DONE; enable drops before the master finishes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr       <= '0;
      r_win       <= '0;
      r_m_addr    <= '0;
      r_m_rw      <= 1'b0;
      r_m_wdata   <= '0;
      r_m_enable  <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant) begin
            r_win      <= w_idx;
            r_ptr      <= (w_idx == IW'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
            r_m_addr   <= bus.req_addr[ADDR_W*w_idx +: ADDR_W];
            r_m_rw     <= bus.req_rw[w_idx];
            r_m_wdata  <= bus.req_wdata[DATA_W*w_idx +: DATA_W];
            r_m_enable <= 1'b1;
          end
        end
        ST_LAUNCH: begin
          if (w_tmo || !bus.m_ready) r_m_enable <= 1'b0;
          if (w_tmo) r_rsp_rdata <= '0;
        end
        ST_BUSY: begin
          if (w_tmo)             r_rsp_rdata <= '0;
          else if (bus.m_ready)  r_rsp_rdata <= bus.m_rdata;
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready = w_grant ? w_gnt : '0;
  assign bus.rsp_valid = (r_state == ST_DONE) ? (NUM_REQ'(1) << r_win) : '0;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.m_addr    = r_m_addr;
  assign bus.m_rw      = r_m_rw;
  assign bus.m_wdata   = r_m_wdata;
  assign bus.m_enable  = r_m_enable;
  assign bus.busy      = (r_state != ST_IDLE);

endmodule
